local_branch_predictor_q: RTL
=============================

// Module: local_branch_predictor_q
// PURPOSE
//  Parametrised two-level local branch predictor: PC-indexed local history table (LHT)
//  selects a saturating counter in a pattern table (PT). Prediction and resolution are
//  decoupled by an in-order in-flight queue, so several branches can be outstanding.
//  Sits in the fetch-stage predictor complex as the local component of the tournament.
// PARAMETERS
//  PC_BITS     10  PC index width; LHT depth = 2**PC_BITS
//  HIST_BITS   10  local history length; PT depth = 2**HIST_BITS
//  CTR_BITS     3  PT saturating counter width (>=2)
//  FIFO_DEPTH   8  max outstanding unresolved predictions (power of 2, >=2)
// PORTS
//  clock          in   1              clock, rising edge
//  reset          in   1              asynchronous, active-high
//  flush          in   1              discard all in-flight predictions
//  pred_valid     in   1              lookup request
//  pred_pc        in   PC_BITS        lookup PC index
//  pred_ready     out  1              = !queue_full (combinational)
//  pred_out_valid out  1              prediction result valid (1-cycle pulse)
//  pred_taken     out  1              predicted direction = MSB of counter
//  pred_ctr       out  CTR_BITS       counter value used for prediction
//  res_valid      in   1              resolution of oldest outstanding branch
//  res_taken      in   1              actual direction
//  res_err        out  1              pulse: res_valid with empty queue
//  occupancy      out  clog2(FIFO_DEPTH+1)  entries in queue
// BEHAVIOUR
//  Reset (async): all LHT entries 0; all PT counters 2**(CTR_BITS-1)-1 (weak not-taken);
//   queue empty; pred_out_valid, pred_taken, pred_ctr, res_err, occupancy = 0; pred_ready=1.
//   Reset asserted mid-operation discards queue and in-flight output the same instant.
//  Lookup: accepted at edge N when pred_valid && pred_ready. h = LHT[pred_pc];
//   c = PT[h]. At N+1: pred_out_valid=1, pred_ctr=c, pred_taken=c[CTR_BITS-1].
//   {pred_pc, h} pushed to queue tail at edge N. Latency fixed at 1 cycle.
//   pred_valid while !pred_ready: ignored, no output, no push.
//  Resolve: at edge with res_valid && occupancy>0, pop head {pc, h}:
//   PT[h] += 1 if res_taken (saturate at 2**CTR_BITS-1), else -= 1 (saturate at 0);
//   LHT[pc] <= {LHT[pc][HIST_BITS-2:0], res_taken} (shifts CURRENT entry, newest bit LSB).
//   res_valid with occupancy==0: no table change, res_err=1 next cycle.
//  Non-speculative: history is updated only at resolve; lookups of a PC with older
//   unresolved instances use the committed history.
//  Same-cycle bypass: if a resolve writes LHT[p] and a lookup reads LHT[p] in the same
//   cycle, the lookup uses the post-update history; likewise if PT index written equals
//   PT index read, lookup sees the post-update counter.
//  Simultaneous push+pop: occupancy unchanged; allowed when full? no - push needs
//   pred_ready, which is evaluated before the pop (full queue rejects lookup even if popping).
//  Queue pointers wrap modulo FIFO_DEPTH; occupancy saturates at FIFO_DEPTH by design.
//  flush: at that edge queue emptied (occupancy=0), pred_valid and res_valid of the same
//   cycle ignored, pred_out_valid=0 next cycle; LHT/PT untouched. flush has priority.
// TESTING
//  1 Reset, lookup pc=5 -> next cycle pred_out_valid=1, pred_taken=0, pred_ctr=3, occupancy=1.
//  2 20x (lookup pc=5, resolve taken) -> LHT[5]=0x3FF, PT[0x3FF] saturates at 7; next
//    lookup pc=5 -> pred_taken=1, pred_ctr=7; further taken resolves keep 7 (no wrap).
//  3 FIFO_DEPTH=8: 9 back-to-back lookups, no resolves -> pred_ready=0 after 8th,
//    9th not accepted, occupancy=8; one resolve -> occupancy=7, pred_ready=1.
//  4 Resolve pc=9 taken (LHT 0->1) with lookup pc=9 same cycle -> lookup uses h=1,
//    pred_ctr=PT[1]=3; PT bypass: PT[h] write+read same cycle returns updated counter.
//  5 res_valid with occupancy=0 -> res_err=1 one cycle, PT/LHT unchanged; flush with
//    occupancy=5 and pred_valid=1 -> occupancy=0, pred_out_valid=0 next cycle.
//  6 Assert reset with occupancy=4 mid-stream -> occupancy=0, outputs 0 immediately;
//    post-reset lookup of trained PC returns pred_ctr=3.

Source files
------------

// File: rtl/local_branch_predictor_q.sv
// Two-level local branch predictor: a PC-indexed history table selects a saturating
// counter in a pattern table, with an in-order queue decoupling lookup from resolve.
module local_branch_predictor_q #(
   parameter int PC_BITS    = 10,
   parameter int HIST_BITS  = 10,
   parameter int CTR_BITS   = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              flush,
   input  logic                              pred_valid,
   input  logic [PC_BITS-1:0]                pred_pc,
   output logic                              pred_ready,
   output logic                              pred_out_valid,
   output logic                              pred_taken,
   output logic [CTR_BITS-1:0]               pred_ctr,
   input  logic                              res_valid,
   input  logic                              res_taken,
   output logic                              res_err,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   occupancy
);

   localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
   localparam int OCC_BITS  = $clog2(FIFO_DEPTH + 1);
   localparam int LHT_DEPTH = 2 ** PC_BITS;
   localparam int PT_DEPTH  = 2 ** HIST_BITS;
   localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [OCC_BITS-1:0] OCC_FULL = OCC_BITS'(FIFO_DEPTH);

   logic [HIST_BITS-1:0] lht    [LHT_DEPTH];
   logic [CTR_BITS-1:0]  pt     [PT_DEPTH];
   logic [PC_BITS-1:0]   q_pc   [FIFO_DEPTH];
   logic [HIST_BITS-1:0] q_hist [FIFO_DEPTH];

   logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
   logic [OCC_BITS-1:0]  count;

   logic                 lookup_fire, resolve_fire;
   logic [PC_BITS-1:0]   head_pc;
   logic [HIST_BITS-1:0] head_hist, new_hist, look_hist;
   logic [CTR_BITS-1:0]  old_ctr, new_ctr, look_ctr;

   // Readiness is judged on the registered count, so a pop in the same cycle
   // does not open a slot for a lookup.
   assign pred_ready = (count != OCC_FULL);
   assign occupancy  = count;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      lookup_fire  = pred_valid && pred_ready && !flush;
      resolve_fire = res_valid && (count != '0) && !flush;

      head_pc   = q_pc[rd_ptr];
      head_hist = q_hist[rd_ptr];
      new_hist  = {lht[head_pc][HIST_BITS-2:0], res_taken};
      old_ctr   = pt[head_hist];

      new_ctr = old_ctr;
      if (res_taken) begin
         if (old_ctr != CTR_MAX) new_ctr = old_ctr + 1'b1;
      end else begin
         if (old_ctr != '0) new_ctr = old_ctr - 1'b1;
      end

      // Lookups see the table contents as they will be after this cycle's resolve.
      look_hist = lht[pred_pc];
      if (resolve_fire && (head_pc == pred_pc)) look_hist = new_hist;
      look_ctr = pt[look_hist];
      if (resolve_fire && (head_hist == look_hist)) look_ctr = new_ctr;
   end

   // NOTE: the prediction tables must come out of reset in a known trained-neutral
   // state, so every entry is reset; that keeps them in flops rather than a RAM macro.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LHT_DEPTH; i++) lht[i] <= '0;
         for (int i = 0; i < PT_DEPTH; i++)  pt[i]  <= CTR_INIT;
      end else if (resolve_fire) begin
         lht[head_pc]  <= new_hist;
         pt[head_hist] <= new_ctr;
      end
   end

   // Queue payload is only read below the occupancy count, so it needs no reset.
   always_ff @(posedge clock) begin
      if (lookup_fire) begin
         q_pc[wr_ptr]   <= pred_pc;
         q_hist[wr_ptr] <= look_hist;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         pred_out_valid <= 1'b0;
         pred_taken     <= 1'b0;
         pred_ctr       <= '0;
         res_err        <= 1'b0;
      end else if (flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         pred_out_valid <= 1'b0;
         res_err        <= 1'b0;
      end else begin
         if (lookup_fire)  wr_ptr <= wr_ptr + 1'b1;
         if (resolve_fire) rd_ptr <= rd_ptr + 1'b1;
         case ({lookup_fire, resolve_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         pred_out_valid <= lookup_fire;
         if (lookup_fire) begin
            pred_ctr   <= look_ctr;
            pred_taken <= look_ctr[CTR_BITS-1];
         end
         res_err <= res_valid && (count == '0);
      end
   end

endmodule
